// File: rtl/errval_map_pipe.sv
// Two-stage LOCO-I prediction-error mapper: sign/modulo reduction and bias test in stage 1,
// MErrval mapping in stage 2, with valid/ready flow control and full throughput.
module errval_map_pipe #(
   parameter int unsigned BPP = 8,
   parameter int unsigned KW  = 4,
   parameter int unsigned CW  = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [BPP:0]   errval_in,
   input  logic           sign_in,
   input  logic [KW-1:0]  k_in,
   input  logic [CW-1:0]  bq_in,
   input  logic [CW-1:0]  nq_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [BPP-1:0] merrval_out,
   output logic [BPP-1:0] errval_out,
   output logic [KW-1:0]  k_out
);

   localparam logic signed [BPP+1:0] Half = {3'b001, {(BPP-1){1'b0}}};
   localparam logic signed [BPP+1:0] Full = {2'b01, {BPP{1'b0}}};

   logic                  s1_valid_q, s1_valid_d;
   logic                  s2_valid_q, s2_valid_d;
   logic                  s2_load, in_acc;
   logic [BPP-1:0]        s1_r_q;
   logic                  s1_special_q;
   logic [KW-1:0]         s1_k_q;
   logic [BPP-1:0]        merr_q, err_q;
   logic [KW-1:0]         k_q;

   logic signed [BPP+1:0] e_ext, e, e_red;
   logic [BPP-1:0]        r_c;
   logic [CW+1:0]         bias_sum;
   logic                  special_c;
   logic [BPP-1:0]        dbl, sp, merr_c;
   logic                  unused_red_hi;

   // Flow control
   always_comb begin
      s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready   = !s1_valid_q || s2_load;
      in_acc     = in_valid && in_ready;
      s1_valid_d = s1_valid_q;
      if (in_acc) begin
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      s2_valid_d = s2_valid_q;
      if (s2_load) begin
         s2_valid_d = 1'b1;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   // Stage 1: sign, modulo reduction into [-2^(BPP-1), 2^(BPP-1)-1], bias condition
   always_comb begin
      e_ext = {errval_in[BPP], errval_in};
      e     = sign_in ? -e_ext : e_ext;
      e_red = e;
      if (e < -Half) begin
         e_red = e + Full;
      end else if (e >= Half) begin
         e_red = e - Full;
      end
      r_c       = e_red[BPP-1:0];
      // 2*B + N in CW+2 bits cannot overflow; non-positive means sign set or zero
      bias_sum  = {bq_in[CW-1], bq_in, 1'b0} + {2'b00, nq_in};
      special_c = (k_in == '0) && (bias_sum[CW+1] || (bias_sum == '0));
   end

   // After reduction the upper bits only repeat the sign
   assign unused_red_hi = ^e_red[BPP+1:BPP];

   // Stage 2: r >= 0 -> 2r + s; r < 0 -> 2|r| - 1 - s, where ~(2r) == -2r - 1
   always_comb begin
      dbl    = {s1_r_q[BPP-2:0], 1'b0};
      sp     = {{(BPP-1){1'b0}}, s1_special_q};
      merr_c = s1_r_q[BPP-1] ? (~dbl - sp) : (dbl + sp);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s1_r_q       <= '0;
         s1_special_q <= 1'b0;
         s1_k_q       <= '0;
         merr_q       <= '0;
         err_q        <= '0;
         k_q          <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (in_acc) begin
            s1_r_q       <= r_c;
            s1_special_q <= special_c;
            s1_k_q       <= k_in;
         end
         if (s2_load) begin
            merr_q <= merr_c;
            err_q  <= s1_r_q;
            k_q    <= s1_k_q;
         end
      end
   end

   assign out_valid   = s2_valid_q;
   assign merrval_out = merr_q;
   assign errval_out  = err_q;
   assign k_out       = k_q;

endmodule
